// File: rtl/imm_packer.sv
// Immediate packer: range-checks a 32-bit immediate for an ImmSrc format and
// scatters it into the immediate fields of an instruction template. Two-stage pipe.
module imm_packer #(
  parameter int CNT_W       = 16,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_ImmSrc,
  input  logic             in_sign,
  input  logic [31:0]      in_Base,
  input  logic [31:0]      in_Imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_Instr,
  output logic             out_Err,
  output logic [CNT_W-1:0] PackCount,
  output logic [CNT_W-1:0] ErrCount
);

  localparam logic [2:0] SRC_R = 3'd1;
  localparam logic [2:0] SRC_I = 3'd2;
  localparam logic [2:0] SRC_S = 3'd3;
  localparam logic [2:0] SRC_B = 3'd4;
  localparam logic [2:0] SRC_J = 3'd5;

  // True when v[31:n-1] are all copies of one bit, i.e. v fits an n-bit signed field.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (n - 1);
    return ((v & mask) == mask) || ((v & mask) == 32'd0);
  endfunction

  logic        s1_valid;
  logic [2:0]  s1_src;
  logic [31:0] s1_base;
  logic [20:0] s1_imm;
  logic        s1_err;

  logic        s2_adv;
  logic        src_bad;
  logic        range_bad;
  logic        in_err;
  logic [31:0] packed_instr;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  always_comb begin
    src_bad   = 1'b0;
    range_bad = 1'b0;
    case (in_ImmSrc)
      SRC_R: range_bad = 1'b0;
      SRC_I: range_bad = in_sign ? !fits_signed(in_Imm, 12) : (in_Imm[31:12] != 20'd0);
      SRC_S: range_bad = !fits_signed(in_Imm, 12);
      SRC_B: range_bad = !fits_signed(in_Imm, 13) || in_Imm[0];
      SRC_J: range_bad = !fits_signed(in_Imm, 21) || in_Imm[0];
      default: src_bad = 1'b1;
    endcase
    in_err = src_bad || (CHECK_RANGE && range_bad);
  end

  // Only bits [20:0] of the immediate ever reach an instruction field.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_src   <= 3'd0;
      s1_base  <= 32'd0;
      s1_imm   <= 21'd0;
      s1_err   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_src  <= in_ImmSrc;
        s1_base <= in_Base;
        s1_imm  <= in_Imm[20:0];
        s1_err  <= in_err;
      end
    end
  end

  always_comb begin
    packed_instr = s1_base;
    if (!s1_err) begin
      case (s1_src)
        SRC_I: packed_instr[31:20] = s1_imm[11:0];
        SRC_S: begin
          packed_instr[31:25] = s1_imm[11:5];
          packed_instr[11:7]  = s1_imm[4:0];
        end
        SRC_B: begin
          packed_instr[31]    = s1_imm[12];
          packed_instr[30:25] = s1_imm[10:5];
          packed_instr[11:8]  = s1_imm[4:1];
          packed_instr[7]     = s1_imm[11];
        end
        SRC_J: begin
          packed_instr[31]    = s1_imm[20];
          packed_instr[30:21] = s1_imm[10:1];
          packed_instr[20]    = s1_imm[11];
          packed_instr[19:12] = s1_imm[19:12];
        end
        default: packed_instr = s1_base;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_Instr <= 32'd0;
      out_Err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_Instr <= packed_instr;
        out_Err   <= s1_err;
      end
    end
  end

  // Delivery counters stick at all-ones rather than wrapping.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      PackCount <= '0;
      ErrCount  <= '0;
    end else if (out_valid && out_ready) begin
      if (out_Err) begin
        if (ErrCount != {CNT_W{1'b1}}) ErrCount <= ErrCount + CNT_W'(1);
      end else begin
        if (PackCount != {CNT_W{1'b1}}) PackCount <= PackCount + CNT_W'(1);
      end
    end
  end

endmodule
